// File: rtl/limn2600_mem_arbiter.sv
// Two-port (instruction/data) arbiter in front of a single-ported synchronous SRAM.
// One transaction in flight; alternating priority; misalignment and timeout complete with an error.
module limn2600_mem_arbiter #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_ack,
  output logic [31:0] i_rdata,
  output logic        i_err,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic        mem_cs,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_rdy,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t      state, state_d;
  logic        prio;            // 1 selects the data port on contention
  logic [7:0]  cnt, cnt_d;
  logic        lat_port;        // 1 = data port owns the transaction
  logic        lat_we;
  logic [31:0] lat_addr, lat_wdata;

  logic        i_elig, d_elig;
  logic        grant, grant_port;
  logic [31:0] grant_addr;
  logic        done, done_err, done_port;
  logic [31:0] done_rdata;

  always_comb begin
    state_d    = state;
    cnt_d      = cnt;
    grant      = 1'b0;
    grant_port = 1'b0;
    grant_addr = i_addr;
    done       = 1'b0;
    done_err   = 1'b0;
    done_rdata = '0;
    // A request still high during its own ack cycle is the one just served
    i_elig     = i_req & ~i_ack;
    d_elig     = d_req & ~d_ack;
    case (state)
      IDLE: begin
        if (i_elig | d_elig) begin
          grant      = 1'b1;
          grant_port = (i_elig & d_elig) ? prio : d_elig;
          grant_addr = grant_port ? d_addr : i_addr;
          if (grant_addr[1:0] != 2'b00) begin
            done     = 1'b1;
            done_err = 1'b1;
          end else begin
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        state_d = WAIT;
        cnt_d   = '0;
      end
      WAIT: begin
        if (mem_rdy) begin
          done       = 1'b1;
          done_rdata = lat_we ? '0 : mem_rdata;
          state_d    = IDLE;
        end else if (cnt == CNT_LAST) begin
          done     = 1'b1;
          done_err = 1'b1;
          state_d  = IDLE;
        end else begin
          cnt_d = cnt + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    // Misaligned completions happen in the grant cycle, before the latch updates
    done_port = grant ? grant_port : lat_port;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      prio      <= 1'b1;
      cnt       <= '0;
      lat_port  <= 1'b0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      i_ack     <= 1'b0;
      i_err     <= 1'b0;
      i_rdata   <= '0;
      d_ack     <= 1'b0;
      d_err     <= 1'b0;
      d_rdata   <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      if (grant) begin
        lat_port  <= grant_port;
        lat_addr  <= grant_addr;
        lat_we    <= grant_port & d_we;
        lat_wdata <= grant_port ? d_wdata : '0;
        prio      <= ~grant_port;
      end
      i_ack <= done & ~done_port;
      i_err <= done & done_err & ~done_port;
      d_ack <= done & done_port;
      d_err <= done & done_err & done_port;
      if (done & ~done_port) i_rdata <= done_rdata;
      if (done & done_port)  d_rdata <= done_rdata;
    end
  end

  assign mem_cs    = (state == ISSUE);
  assign mem_we    = lat_we;
  assign mem_addr  = lat_addr;
  assign mem_wdata = lat_wdata;

endmodule

// File: tb/tb_limn2600_mem_arbiter.sv
// Directed bench for limn2600_mem_arbiter: cycle-by-cycle vector table plus
// hand-written contention and reset-in-flight sequences. SRAM is a small ready model.
module tb_limn2600_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req, d_req, d_we;
  logic [31:0] i_addr, d_addr, d_wdata;
  logic        i_ack, i_err, d_ack, d_err;
  logic [31:0] i_rdata, d_rdata;
  logic        mem_cs, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_rdy = 1'b0;
  logic [31:0] mem_rdata = 32'h0;

  logic        rdy_en;
  logic [31:0] sdata;

  int tests = 0;
  int fails = 0;

  limn2600_mem_arbiter #(.TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata), .i_err(i_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
    .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdy(mem_rdy), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // SRAM: ready (with data) the edge after chip select is sampled, when enabled
  always @(posedge clk) begin
    mem_rdy   <= mem_cs && rdy_en;
    mem_rdata <= (mem_cs && rdy_en) ? sdata : 32'h0;
  end

  typedef struct {
    string       name;
    bit          ireq;
    logic [31:0] iaddr;
    bit          dreq, dwe;
    logic [31:0] daddr, dwdata;
    bit          rdy;
    logic [31:0] sd;
    bit          cs, bus, we;
    logic [31:0] addr, wdata;
    bit          ia, ie;
    logic [31:0] ird;
    bit          da, de;
    logic [31:0] drd;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(string n, bit ir, logic [31:0] ia, bit dr, bit dw,
                              logic [31:0] da, logic [31:0] dwd, bit rdy, logic [31:0] sd,
                              bit cs, bit bus, bit we, logic [31:0] ad, logic [31:0] wd,
                              bit iak, bit ier, logic [31:0] ird,
                              bit dak, bit der, logic [31:0] drd);
    vec_t v;
    v.name = n; v.ireq = ir; v.iaddr = ia; v.dreq = dr; v.dwe = dw; v.daddr = da;
    v.dwdata = dwd; v.rdy = rdy; v.sd = sd; v.cs = cs; v.bus = bus; v.we = we;
    v.addr = ad; v.wdata = wd; v.ia = iak; v.ie = ier; v.ird = ird;
    v.da = dak; v.de = der; v.drd = drd;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(string n, bit ok, logic [31:0] act, logic [31:0] req);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL %s: actual %h, required %h", n, act, req);
    end
  endtask

  initial begin
    vec_t v;
    bit   ok;
    int   n, grants;
    bit   both_ack;
    logic [31:0] exp_addr;

    rst = 1'b1; i_req = 0; i_addr = '0; d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
    rdy_en = 1'b1; sdata = '0;

    // cycle-by-cycle vectors: inputs before the edge, expected outputs after it
    //                  name           ireq iaddr       dreq dwe daddr          dwdata        rdy sdata        cs bus we addr           wdata         ia ie ird           da de drd
    tbl.push_back(mk("rd_issue",       0, 32'h0,       1, 0, 32'h10,       32'h0,        1, 32'hDEADBEEF, 1, 1, 0, 32'h10,       32'h0,        0, 0, 32'h0,        0, 0, 32'h0));
    tbl.push_back(mk("rd_wait",        0, 32'h0,       1, 0, 32'h10,       32'h0,        1, 32'hDEADBEEF, 0, 1, 0, 32'h10,       32'h0,        0, 0, 32'h0,        0, 0, 32'h0));
    tbl.push_back(mk("rd_ack",         0, 32'h0,       1, 0, 32'h10,       32'h0,        1, 32'hDEADBEEF, 0, 0, 0, 32'h0,        32'h0,        0, 0, 32'h0,        1, 0, 32'hDEADBEEF));
    tbl.push_back(mk("rd_held_ign",    0, 32'h0,       1, 0, 32'h10,       32'h0,        1, 32'hDEADBEEF, 0, 0, 0, 32'h0,        32'h0,        0, 0, 32'h0,        0, 0, 32'h0));
    tbl.push_back(mk("prio_i_issue",   1, 32'h40,      1, 0, 32'h14,       32'h0,        1, 32'h11112222, 1, 1, 0, 32'h40,       32'h0,        0, 0, 32'h0,        0, 0, 32'h0));
    tbl.push_back(mk("prio_i_wait",    1, 32'h40,      1, 0, 32'h14,       32'h0,        1, 32'h11112222, 0, 0, 0, 32'h0,        32'h0,        0, 0, 32'h0,        0, 0, 32'h0));
    tbl.push_back(mk("prio_i_ack",     1, 32'h40,      1, 0, 32'h14,       32'h0,        1, 32'h11112222, 0, 0, 0, 32'h0,        32'h0,        1, 0, 32'h11112222, 0, 0, 32'h0));
    tbl.push_back(mk("d_after_i",      1, 32'h40,      1, 0, 32'h14,       32'h0,        1, 32'h33334444, 1, 1, 0, 32'h14,       32'h0,        0, 0, 32'h0,        0, 0, 32'h0));
    tbl.push_back(mk("d_after_wait",   0, 32'h40,      1, 0, 32'h14,       32'h0,        1, 32'h33334444, 0, 0, 0, 32'h0,        32'h0,        0, 0, 32'h0,        0, 0, 32'h0));
    tbl.push_back(mk("d_after_ack",    0, 32'h40,      1, 0, 32'h14,       32'h0,        1, 32'h33334444, 0, 0, 0, 32'h0,        32'h0,        0, 0, 32'h0,        1, 0, 32'h33334444));
    tbl.push_back(mk("idle1",          0, 32'h0,       0, 0, 32'h0,        32'h0,        1, 32'h0,        0, 0, 0, 32'h0,        32'h0,        0, 0, 32'h0,        0, 0, 32'h0));
    tbl.push_back(mk("wr_issue",       0, 32'h0,       1, 1, 32'h00F80004, 32'h12345678, 1, 32'hDEADBEEF, 1, 1, 1, 32'h00F80004, 32'h12345678, 0, 0, 32'h0,        0, 0, 32'h0));
    tbl.push_back(mk("wr_wait",        0, 32'h0,       1, 1, 32'h00F80004, 32'h12345678, 1, 32'hDEADBEEF, 0, 1, 1, 32'h00F80004, 32'h12345678, 0, 0, 32'h0,        0, 0, 32'h0));
    tbl.push_back(mk("wr_ack",         0, 32'h0,       1, 1, 32'h00F80004, 32'h12345678, 1, 32'hDEADBEEF, 0, 0, 0, 32'h0,        32'h0,        0, 0, 32'h0,        1, 0, 32'h0));
    tbl.push_back(mk("idle2",          0, 32'h0,       0, 0, 32'h0,        32'h0,        1, 32'h0,        0, 0, 0, 32'h0,        32'h0,        0, 0, 32'h0,        0, 0, 32'h0));
    tbl.push_back(mk("mis_err",        1, 32'h2,       0, 0, 32'h0,        32'h0,        1, 32'h0,        0, 0, 0, 32'h0,        32'h0,        1, 1, 32'h0,        0, 0, 32'h0));
    tbl.push_back(mk("mis_held_ign",   1, 32'h2,       0, 0, 32'h0,        32'h0,        1, 32'h0,        0, 0, 0, 32'h0,        32'h0,        0, 0, 32'h0,        0, 0, 32'h0));
    tbl.push_back(mk("idle3",          0, 32'h0,       0, 0, 32'h0,        32'h0,        1, 32'h0,        0, 0, 0, 32'h0,        32'h0,        0, 0, 32'h0,        0, 0, 32'h0));
    tbl.push_back(mk("to_issue",       1, 32'h100,     0, 0, 32'h0,        32'h0,        0, 32'h0,        1, 1, 0, 32'h100,      32'h0,        0, 0, 32'h0,        0, 0, 32'h0));
    for (int unsigned w = 0; w < 4; w++)
      tbl.push_back(mk("to_wait",      1, 32'h100,     0, 0, 32'h0,        32'h0,        0, 32'h0,        0, 1, 0, 32'h100,      32'h0,        0, 0, 32'h0,        0, 0, 32'h0));
    tbl.push_back(mk("to_err",         1, 32'h100,     0, 0, 32'h0,        32'h0,        0, 32'h0,        0, 0, 0, 32'h0,        32'h0,        1, 1, 32'h0,        0, 0, 32'h0));
    tbl.push_back(mk("post_to_issue",  0, 32'h0,       1, 0, 32'h20,       32'h0,        1, 32'hCAFEF00D, 1, 1, 0, 32'h20,       32'h0,        0, 0, 32'h0,        0, 0, 32'h0));
    tbl.push_back(mk("post_to_wait",   0, 32'h0,       1, 0, 32'h20,       32'h0,        1, 32'hCAFEF00D, 0, 0, 0, 32'h0,        32'h0,        0, 0, 32'h0,        0, 0, 32'h0));
    tbl.push_back(mk("post_to_ack",    0, 32'h0,       1, 0, 32'h20,       32'h0,        1, 32'hCAFEF00D, 0, 0, 0, 32'h0,        32'h0,        0, 0, 32'h0,        1, 0, 32'hCAFEF00D));
    tbl.push_back(mk("idle4",          0, 32'h0,       0, 0, 32'h0,        32'h0,        1, 32'h0,        0, 0, 0, 32'h0,        32'h0,        0, 0, 32'h0,        0, 0, 32'h0));

    // reset state
    tick(); tick();
    tests++;
    if ({mem_cs, mem_we, mem_addr, mem_wdata, i_ack, i_err, i_rdata, d_ack, d_err, d_rdata} != '0) begin
      fails++;
      $display("FAIL reset_state: cs=%0b we=%0b addr=%h wd=%h ia=%0b ie=%0b ird=%h da=%0b de=%0b drd=%h, required all zero",
               mem_cs, mem_we, mem_addr, mem_wdata, i_ack, i_err, i_rdata, d_ack, d_err, d_rdata);
    end
    rst = 1'b0;

    foreach (tbl[k]) begin
      v = tbl[k];
      i_req = v.ireq; i_addr = v.iaddr; d_req = v.dreq; d_we = v.dwe; d_addr = v.daddr;
      d_wdata = v.dwdata; rdy_en = v.rdy; sdata = v.sd;
      tick();
      ok = (mem_cs == v.cs) && (i_ack == v.ia) && (i_err == v.ie) && (d_ack == v.da) && (d_err == v.de)
        && (!v.ia || i_rdata == v.ird) && (!v.da || d_rdata == v.drd)
        && (!v.bus || (mem_we == v.we && mem_addr == v.addr && mem_wdata == v.wdata));
      tests++;
      if (!ok) begin
        fails++;
        $display("FAIL %s (row %0d): actual cs=%0b we=%0b addr=%h wd=%h ia=%0b ie=%0b ird=%h da=%0b de=%0b drd=%h; required cs=%0b we=%0b addr=%h wd=%h ia=%0b ie=%0b ird=%h da=%0b de=%0b drd=%h",
                 v.name, k, mem_cs, mem_we, mem_addr, mem_wdata, i_ack, i_err, i_rdata, d_ack, d_err, d_rdata,
                 v.cs, v.we, v.addr, v.wdata, v.ia, v.ie, v.ird, v.da, v.de, v.drd);
      end
    end

    // contention straight out of reset: data first, then strict alternation
    rst = 1'b1;
    tick();
    i_req = 1; i_addr = 32'h40; d_req = 1; d_we = 0; d_addr = 32'h80; d_wdata = '0;
    rdy_en = 1; sdata = 32'h77;
    rst = 1'b0;
    grants = 0; both_ack = 0; exp_addr = 32'h80;
    for (int unsigned j = 0; j < 12; j++) begin
      tick();
      if (i_ack && d_ack) both_ack = 1;
      if (mem_cs) begin
        check("alt_grant_addr", mem_addr == exp_addr, mem_addr, exp_addr);
        exp_addr = (exp_addr == 32'h80) ? 32'h40 : 32'h80;
        grants++;
      end
    end
    check("alt_grant_count", grants == 4, 32'(grants), 32'd4);
    check("ack_exclusive", !both_ack, {31'h0, both_ack}, 32'h0);
    i_req = 0; d_req = 0;
    tick(); tick(); tick();

    // reset while waiting on a silent SRAM
    d_req = 1; d_we = 0; d_addr = 32'h30; rdy_en = 0;
    tick();
    check("rstw_issue_cs", mem_cs == 1'b1, {31'h0, mem_cs}, 32'h1);
    tick(); tick();
    #2 rst = 1'b1;
    #1;
    check("rstw_async_clear", {mem_cs, mem_we, d_ack, d_err, i_ack} == '0 && mem_addr == '0,
          mem_addr, 32'h0);
    d_req = 0;
    tick(); tick();
    rst = 1'b0;
    for (int unsigned j = 0; j < 6; j++) begin
      tick();
      check("rstw_no_ack", !d_ack && !i_ack && !mem_cs, {29'h0, mem_cs, i_ack, d_ack}, 32'h0);
    end

    // request pending across reset release is arbitrated on the first edge
    rst = 1'b1;
    d_req = 1; d_we = 0; d_addr = 32'h34; rdy_en = 1; sdata = 32'h5A5A5A5A;
    tick();
    rst = 1'b0;
    tick();
    check("first_edge_cs", mem_cs == 1'b1 && mem_addr == 32'h34, mem_addr, 32'h34);
    n = 1;
    while (!d_ack && n < 10) begin
      tick();
      n++;
    end
    check("fresh_ack_latency", d_ack && n == 3, 32'(n), 32'd3);
    check("fresh_rdata", d_ack && !d_err && d_rdata == 32'h5A5A5A5A, d_rdata, 32'h5A5A5A5A);
    d_req = 0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/limn2600_mem_arbiter.md
LIMN2600_MEM_ARBITER -- requirements
Module: limn2600_mem_arbiter

Interface
REQ-001 Parameter: TIMEOUT, 15, max WAIT cycles without mem_rdy before error completion (legal 1..255).
REQ-002 clk  input  1  single clock; all state on rising edge.
REQ-003 rst  input  1  asynchronous active-high reset.
REQ-004 i_req  input  1  instruction-port read request; held until i_ack.
REQ-005 i_addr  input  32  instruction-port byte address.
REQ-006 i_ack  output  1  one-cycle completion pulse, instruction port.
REQ-007 i_rdata  output  32  read data, valid while i_ack=1.
REQ-008 i_err  output  1  error flag, valid while i_ack=1.
REQ-009 d_req  input  1  data-port request; held until d_ack.
REQ-010 d_we  input  1  data-port write enable (1=write, 0=read).
REQ-011 d_addr  input  32  data-port byte address.
REQ-012 d_wdata  input  32  data-port write data.
REQ-013 d_ack, d_rdata, d_err  output  1/32/1  as i_ack/i_rdata/i_err, data port.
REQ-014 mem_cs, mem_we  output  1/1  SRAM chip select and write enable.
REQ-015 mem_addr, mem_wdata  output  32/32  SRAM address and write data.
REQ-016 mem_rdy, mem_rdata  input  1/32  SRAM ready (registered, asserts the edge after cs sampled) and read data.

Function
REQ-017 FSM states SHALL be IDLE, ISSUE, WAIT; exactly one transaction outstanding.
REQ-018 IDLE: a port is eligible when its req=1 and its ack is 0 this cycle (req held through its ack cycle is ignored).
REQ-019 Arbitration: one eligible port -> grant it; both eligible -> grant port named by prio flag; prio SHALL flip to the other port after every grant.
REQ-020 On grant, addr, we (i-port we=0), wdata, port id SHALL be latched; all mem_* outputs driven from latched values only.
REQ-021 Misaligned grant (addr[1:0]!=0): no SRAM access; ack+err=1 on the next edge; FSM stays IDLE.
REQ-022 Aligned grant -> ISSUE; ISSUE drives mem_cs=1 for exactly one cycle, then -> WAIT with mem_cs=0.
REQ-023 WAIT, mem_rdy=1: capture mem_rdata into granted port rdata, pulse ack (err=0) next cycle, -> IDLE.
REQ-024 Timeout counter (8 bits) SHALL clear on entering WAIT, increment each WAIT cycle with mem_rdy=0; at TIMEOUT: ack+err=1, rdata=0, -> IDLE.
REQ-025 Latency: req sampled at edge E0 -> mem_cs high E0..E1 -> rdy sampled E2 -> ack high E2..E3; peak throughput one transaction per 3 cycles.
REQ-026 Writes SHALL complete via mem_rdy like reads; rdata on write ack is don't-care-free and SHALL be 0.
REQ-027 Only one of i_ack/d_ack high per cycle; acks are single-cycle pulses.
REQ-028 mem_we, mem_addr, mem_wdata SHALL hold latched values from ISSUE until return to IDLE.
REQ-029 mem_rdy while in IDLE or ISSUE SHALL be ignored.

Reset
REQ-030 rst=1 SHALL asynchronously force IDLE, prio=data port, counter=0, mem_cs=0, mem_we=0, all acks/errs=0, rdata/mem_addr/mem_wdata=0.
REQ-031 Reset mid-transaction SHALL drop it silently (no ack); requester re-issues after release.
REQ-032 First edge after rst deasserts SHALL perform arbitration normally.

Verification
REQ-033 d_req read addr=0x00000010 alone, SRAM returns 0xDEADBEEF -> mem_cs one cycle, d_ack+d_rdata=0xDEADBEEF 3 edges after req, d_err=0.
REQ-034 i_req and d_req same cycle after reset -> d granted first, i granted on the next IDLE; continued contention alternates strictly.
REQ-035 d_req write addr=0x00F80004 data=0x12345678 -> mem_we=1, mem_addr/mem_wdata match during ISSUE, d_ack with d_rdata=0.
REQ-036 i_addr=0x00000002 -> no mem_cs, i_ack+i_err=1 one edge after grant.
REQ-037 mem_rdy tied 0, TIMEOUT=4 -> ack+err=1 after 4 WAIT cycles, FSM returns IDLE and serves next request.
REQ-038 rst pulsed during WAIT -> no ack, mem_cs=0 immediately, fresh request afterwards completes normally.
